// File: rtl/landing_gear_plant.sv
// Closed-loop plant for a landing-gear controller: gear travel FSM with position
// counter, takeoff timer and a sticky pump-against-lock overrun monitor.
module landing_gear_plant #(
  parameter int TRAVEL_CYCLES  = 16,
  parameter int TIMEUP_CYCLES  = 8,
  parameter int OVERRUN_CYCLES = 4,
  parameter int POS_W          = 8
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Valve,
  input  logic             Pump,
  input  logic             Timer,
  output logic             GearIsDown,
  output logic             GearIsUp,
  output logic             TimeUp,
  output logic             GearMoving,
  output logic [POS_W-1:0] GearPos,
  output logic             OverRun,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    LOCK_DN = 3'd0,
    LOCK_UP = 3'd1,
    MOVE_UP = 3'd2,
    MOVE_DN = 3'd3,
    HALT    = 3'd4,
    SETTLE  = 3'd5
  } state_t;

  localparam int OV_W = $clog2(OVERRUN_CYCLES + 1);
  localparam logic [POS_W-1:0] TRAVEL    = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0] TRAVEL_M1 = POS_W'(TRAVEL_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] TU_MAX    = POS_W'(TIMEUP_CYCLES);
  localparam logic [OV_W-1:0]  OV_MAX    = OV_W'(OVERRUN_CYCLES);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_d;
  logic [POS_W-1:0] tmr_q, tmr_d;
  logic [OV_W-1:0]  ov_q, ov_d;
  logic             cmd_dn, cmd_up, against;

  assign cmd_dn = Pump & Valve;
  assign cmd_up = Pump & ~Valve;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= LOCK_DN;
      GearPos <= TRAVEL;
    end else begin
      state_q <= state_d;
      GearPos <= pos_d;
    end
  end

  // Leaving a lock, HALT or SETTLE never moves the gear; only MOVE_* steps it.
  always_comb begin
    state_d = state_q;
    pos_d   = GearPos;
    case (state_q)
      LOCK_DN: if (cmd_up) state_d = MOVE_UP;
      LOCK_UP: if (cmd_dn) state_d = MOVE_DN;
      MOVE_UP: begin
        if (!Pump) state_d = HALT;
        else if (Valve) state_d = SETTLE;
        else if (GearPos <= POS_ONE) begin
          pos_d   = '0;
          state_d = LOCK_UP;
        end else pos_d = GearPos - POS_ONE;
      end
      MOVE_DN: begin
        if (!Pump) state_d = HALT;
        else if (!Valve) state_d = SETTLE;
        else if (GearPos >= TRAVEL_M1) begin
          pos_d   = TRAVEL;
          state_d = LOCK_DN;
        end else pos_d = GearPos + POS_ONE;
      end
      HALT: begin
        if (cmd_dn) state_d = MOVE_DN;
        else if (cmd_up) state_d = MOVE_UP;
      end
      SETTLE: begin
        if (cmd_dn) state_d = MOVE_DN;
        else if (cmd_up) state_d = MOVE_UP;
        else state_d = HALT;
      end
      default: begin
        state_d = LOCK_DN;
        pos_d   = TRAVEL;
      end
    endcase
  end

  assign GearIsDown = (state_q == LOCK_DN);
  assign GearIsUp   = (state_q == LOCK_UP);
  assign GearMoving = (state_q == MOVE_UP) || (state_q == MOVE_DN);
  assign dbg_state  = state_q;

  assign against = (GearIsDown & cmd_dn) | (GearIsUp & cmd_up);

  always_comb begin
    tmr_d = tmr_q;
    if (Timer) tmr_d = '0;
    else if (tmr_q != TU_MAX) tmr_d = tmr_q + POS_ONE;
    ov_d = '0;
    if (against) ov_d = (ov_q == OV_MAX) ? ov_q : ov_q + OV_W'(1);
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      tmr_q   <= '0;
      TimeUp  <= 1'b0;
      ov_q    <= '0;
      OverRun <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      TimeUp  <= (tmr_d == TU_MAX);
      ov_q    <= ov_d;
      OverRun <= OverRun | (ov_d == OV_MAX);
    end
  end

endmodule

// File: tb/tb_landing_gear_plant.sv
// Directed bench for landing_gear_plant: a vector table for the mixed motion/timer
// path, then hand sequences for full travel, reversal, timer, overrun and async clear.
module tb_landing_gear_plant;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic       Valve = 1'b0;
  logic       Pump  = 1'b0;
  logic       Timer = 1'b1;
  logic       GearIsDown, GearIsUp, TimeUp, GearMoving, OverRun;
  logic [7:0] GearPos;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  landing_gear_plant #(
    .TRAVEL_CYCLES(16), .TIMEUP_CYCLES(8), .OVERRUN_CYCLES(4), .POS_W(8)
  ) dut (
    .Clock(Clock), .Clear(Clear), .Valve(Valve), .Pump(Pump), .Timer(Timer),
    .GearIsDown(GearIsDown), .GearIsUp(GearIsUp), .TimeUp(TimeUp),
    .GearMoving(GearMoving), .GearPos(GearPos), .OverRun(OverRun),
    .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       v, p, t;
    logic       dn, up, mv, tu, ov;
    logic [7:0] pos;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic v, p, t, dn, up, mv, input int pos,
                              input logic tu, ov);
    vec_t r;
    r.v = v; r.p = p; r.t = t;
    r.dn = dn; r.up = up; r.mv = mv; r.pos = 8'(pos); r.tu = tu; r.ov = ov;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic dn, up, mv, input int pos,
                           input logic tu, ov);
    check({name, ".down"},   32'(GearIsDown), 32'(dn));
    check({name, ".up"},     32'(GearIsUp),   32'(up));
    check({name, ".moving"}, 32'(GearMoving), 32'(mv));
    check({name, ".pos"},    32'(GearPos),    32'(pos));
    check({name, ".timeup"}, 32'(TimeUp),     32'(tu));
    check({name, ".overrun"},32'(OverRun),    32'(ov));
  endtask

  // Drive inputs just after an edge, then sample 1 ns after the next one.
  task automatic step(input logic v, p, t);
    Valve = v; Pump = p; Timer = t;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Valve = 1'b0; Pump = 1'b0; Timer = 1'b1;
    Clear = 1'b1;
    #1;
    check_all("reset", 1, 0, 0, 16, 0, 0);
    @(negedge Clock);
    Clear = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,1, 1,0,0, 16, 0,0);  // idle in LOCK_DN
    tbl[1]  = mk(0,1,1, 0,0,1, 16, 0,0);  // leave lock, no motion yet
    tbl[2]  = mk(0,1,1, 0,0,1, 15, 0,0);
    tbl[3]  = mk(0,1,1, 0,0,1, 14, 0,0);
    tbl[4]  = mk(0,0,1, 0,0,0, 14, 0,0);  // HALT
    tbl[5]  = mk(0,0,0, 0,0,0, 14, 0,0);  // timer count 1
    tbl[6]  = mk(0,1,0, 0,0,1, 14, 0,0);  // resume: MOVE_UP, count 2
    tbl[7]  = mk(0,1,0, 0,0,1, 13, 0,0);
    tbl[8]  = mk(1,1,0, 0,0,0, 13, 0,0);  // SETTLE
    tbl[9]  = mk(1,1,0, 0,0,1, 13, 0,0);  // MOVE_DN
    tbl[10] = mk(1,1,0, 0,0,1, 14, 0,0);
    tbl[11] = mk(0,1,0, 0,0,0, 14, 0,0);  // SETTLE again, count 7
    tbl[12] = mk(0,0,0, 0,0,0, 14, 1,0);  // HALT, count 8 -> TimeUp
    tbl[13] = mk(0,0,1, 0,0,0, 14, 0,0);  // timer cleared
    tbl[14] = mk(1,1,1, 0,0,1, 14, 0,0);
    tbl[15] = mk(1,1,1, 0,0,1, 15, 0,0);
    tbl[16] = mk(1,1,1, 1,0,0, 16, 0,0);  // reaches LOCK_DN
    tbl[17] = mk(1,1,1, 1,0,0, 16, 0,0);  // pump against lock, count 1

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].p, tbl[i].t);
      check_all($sformatf("vec%0d", i), tbl[i].dn, tbl[i].up, tbl[i].mv,
                int'(tbl[i].pos), tbl[i].tu, tbl[i].ov);
    end

    // Full retract: lock drops after 1 cycle, GearIsUp after 17.
    do_reset();
    step(0, 1, 1);
    check_all("retract_c1", 0, 0, 1, 16, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 1);
      if (k < 16) check_all($sformatf("retract_c%0d", k + 1), 0, 0, 1, 16 - k, 0, 0);
      else        check_all("retract_locked", 0, 1, 0, 0, 0, 0);
    end
    // Pump-up against the up lock also trips the overrun monitor.
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 1);
      check_all($sformatf("up_against_%0d", k), 0, 1, 0, 0, 0, (k == 4));
    end
    // From LOCK_UP, command down: pos 0 (MOVE_DN), then 1.
    step(1, 1, 1);
    check_all("extend_c1", 0, 0, 1, 0, 0, 1);
    step(1, 1, 1);
    check_all("extend_c2", 0, 0, 1, 1, 0, 1);

    // Reversal at position 5.
    do_reset();
    step(0, 1, 1);
    for (int k = 1; k <= 11; k++) step(0, 1, 1);
    check_all("rev_at5", 0, 0, 1, 5, 0, 0);
    step(1, 1, 1);
    check_all("rev_settle", 0, 0, 0, 5, 0, 0);
    step(1, 1, 1);
    check_all("rev_movedn", 0, 0, 1, 5, 0, 0);
    for (int p = 6; p <= 16; p++) begin
      step(1, 1, 1);
      if (p < 16) check_all($sformatf("rev_pos%0d", p), 0, 0, 1, p, 0, 0);
      else        check_all("rev_locked", 1, 0, 0, 16, 0, 0);
    end

    // Timer: expires on the 8th edge after release, holds, clears on one Timer pulse.
    do_reset();
    step(0, 0, 1);
    for (int k = 1; k <= 11; k++) begin
      step(0, 0, 0);
      check($sformatf("timer_e%0d", k), 32'(TimeUp), 32'(k >= 8));
    end
    step(0, 0, 1);
    check("timer_clear", 32'(TimeUp), 32'd0);
    step(0, 0, 0);
    check("timer_restart", 32'(TimeUp), 32'd0);

    // Overrun: 3-cycle burst, gap, 4-cycle burst.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 1);
      check($sformatf("ov_b1_%0d", k), 32'(OverRun), 32'd0);
    end
    step(0, 0, 1);
    check("ov_gap", 32'(OverRun), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 1);
      check($sformatf("ov_b2_%0d", k), 32'(OverRun), 32'(k == 4));
    end
    for (int k = 1; k <= 5; k++) step(0, 0, 1);
    check_all("ov_sticky", 1, 0, 0, 16, 0, 1);

    // Async clear mid-travel with TimeUp and OverRun both set.
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, 1, 0);
    step(0, 1, 0);
    for (int k = 1; k <= 9; k++) step(0, 1, 0);
    check_all("async_pre", 0, 0, 1, 7, 1, 1);
    #2;
    Clear = 1'b1;
    #1;
    check_all("async_clear", 1, 0, 0, 16, 0, 0);
    #1;
    Clear = 1'b0;
    Pump  = 1'b0;
    Timer = 1'b1;
    step(0, 0, 1);
    check_all("async_after", 1, 0, 0, 16, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/landing_gear_plant.md
Name: landing_gear_plant

Overview:
- Responder-side model of the landing-gear hydraulics and takeoff timer. It consumes the gear controller's actuator commands (Valve, Pump, Timer) and produces the sensor feedback the controller reads (GearIsDown, GearIsUp, TimeUp).
- Used as the closed-loop plant in controller testbenches and as a synthesizable hardware-in-the-loop stand-in on FPGA demo boards.
- Contains a gear-travel state machine with a position counter, a takeoff timer, and an overrun fault monitor.

Parameters:
- TRAVEL_CYCLES, 16, number of motion cycles for full travel between locked-up and locked-down; legal range is 1 to 2^POS_W-1.
- TIMEUP_CYCLES, 8, number of counting cycles after Timer release before TimeUp asserts; legal range is 1 to 2^POS_W-1.
- OVERRUN_CYCLES, 4, number of consecutive cycles of pump-against-lock before OverRun latches; must be at least 1.
- POS_W, 8, width of the position and timer counters.

Ports:
- Clock, input, 1, sole clock; rising edge.
- Clear, input, 1, asynchronous active-high reset.
- Valve, input, 1, 1 = DOWN direction, 0 = UP direction.
- Pump, input, 1, 1 = hydraulic pump running.
- Timer, input, 1, 1 = hold timer in reset, 0 = count.
- GearIsDown, output, 1, gear locked down.
- GearIsUp, output, 1, gear locked up.
- TimeUp, output, 1, takeoff timer expired.
- GearMoving, output, 1, gear in motion this cycle.
- GearPos, output, POS_W, position; 0 = fully up, TRAVEL_CYCLES = fully down.
- OverRun, output, 1, sticky fault: pump driven against a lock.

Behaviour:
- Reset (Clear=1, asynchronous): state=LOCK_DN, GearPos=TRAVEL_CYCLES, timer count=0, overrun count=0, OverRun=0. Resulting outputs: GearIsDown=1, GearIsUp=0, TimeUp=0, GearMoving=0. Clear asserted mid-travel aborts immediately to this reset state.
- Direction terms: "cmd_dn" = Pump & Valve; "cmd_up" = Pump & ~Valve.
- LOCK_DN: cmd_up -> MOVE_UP; otherwise stay. GearPos=TRAVEL_CYCLES.
- LOCK_UP: cmd_dn -> MOVE_DN; otherwise stay. GearPos=0.
- MOVE_UP:
  - cmd_up: GearPos decrements by 1. If GearPos was 1, go to LOCK_UP.
  - Pump=0: go to HALT with no position change.
  - cmd_dn: go to SETTLE with no position change.
- MOVE_DN: mirror of MOVE_UP. cmd_dn increments GearPos; reaching TRAVEL_CYCLES goes to LOCK_DN. Pump=0 -> HALT. cmd_up -> SETTLE.
- HALT: mid-travel with the pump off; GearPos holds. cmd_dn -> MOVE_DN; cmd_up -> MOVE_UP; otherwise stay.
- SETTLE: exactly one cycle, no motion (models valve reversal). Next state: cmd_dn -> MOVE_DN, cmd_up -> MOVE_UP, otherwise HALT.
- Output decode (Moore, from registered state only):
  - GearIsDown = (state==LOCK_DN).
  - GearIsUp = (state==LOCK_UP).
  - GearMoving = state is MOVE_UP or MOVE_DN.
  - GearIsDown and GearIsUp are never both 1.
- Travel latency: from a lock with the command held continuously, the opposite lock indication asserts TRAVEL_CYCLES+1 cycles after the command is first sampled. The departed lock indication drops 1 cycle after the command is first sampled.
- Saturation: GearPos never leaves the range 0..TRAVEL_CYCLES.
- Timer:
  - Timer=1 clears the count to 0 on the next edge.
  - Timer=0 increments the count, saturating at TIMEUP_CYCLES.
  - TimeUp = (count==TIMEUP_CYCLES), registered decode.
  - Timer=1 while TimeUp=1 deasserts TimeUp on the next edge.
- OverRun:
  - The overrun count increments each cycle in which (LOCK_DN & cmd_dn) or (LOCK_UP & cmd_up) holds; any other cycle zeroes it.
  - When the count reaches OVERRUN_CYCLES, OverRun latches to 1 and stays 1 until Clear.
  - Motion behaviour is unaffected by OverRun.

Test Plan:
- Retract, T=16: Clear pulse, then Valve=0, Pump=1 held. Required: GearIsDown=0 after 1 cycle; GearMoving=1; GearPos counts 16 down to 0; GearIsUp=1 exactly 17 cycles after Pump first sampled.
- Halt and resume: retract, drop Pump when GearPos=10. Required: state HALT, GearPos stays 10, GearMoving=0. Re-assert Pump: GearPos decrements from the next cycle onward.
- Reversal: while retracting at GearPos=5, set Valve=1. Required: one SETTLE cycle with GearPos=5 and GearMoving=0; then GearPos counts 6, 7, ... to 16; then GearIsDown=1.
- Timer, TIMEUP_CYCLES=8: Timer=1 then Timer=0. Required: TimeUp=1 on the 8th edge after release and held there. Timer=1 for one cycle clears TimeUp on the next edge.
- OverRun, OVERRUN_CYCLES=4: in LOCK_DN drive Pump=1, Valve=1 for 3 cycles, then 1 idle cycle, then 4 cycles. Required: OverRun stays 0 after the first burst and reaches 1 after the 4th cycle of the second burst. OverRun remains 1 with idle inputs until Clear.
- Async reset mid-travel: assert Clear between clock edges at GearPos=7 while moving. Required: GearPos=16, GearIsDown=1, TimeUp=0 and OverRun=0 immediately, without waiting for a clock edge.
